bp_mem_cmd_router: RTL and testbench

BP_MEM_CMD_ROUTER -- requirements
Module: bp_mem_cmd_router

---
 rtl/bp_mem_cmd_router.sv | 262 ++++++++++++++++++++++++++
 tb/tb_bp_mem_cmd_router.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_mem_cmd_router.sv
// Message types and address map shared by the command router and its bench.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bp_mem_pkg;
    typedef enum logic [1:0] {
        e_bp_inv_cfg,
        e_bp_unicore_cfg,
        e_bp_multicore_cfg
    } bp_params_e;

    localparam int         paddr_width_gp = 40;
    localparam logic [3:0] host_dev_gp    = 4'd1;
    localparam logic [3:0] clint_dev_gp   = 4'd2;

    typedef struct packed {
        logic [3:0]                msg_type;
        logic [3:0]                lce_id;
        logic [paddr_width_gp-1:0] addr;
        logic [63:0]               data;
    } bp_cce_mem_msg_s;

    // Start of cacheable DRAM; everything below it is the local device space.
    // All current configurations share the same base.
    function automatic logic [paddr_width_gp-1:0] dram_base(input bp_params_e cfg);
        case (cfg)
            e_bp_multicore_cfg: return 40'h00_8000_0000;
            default:            return 40'h00_8000_0000;
        endcase
    endfunction
endpackage

// Generic circular FIFO used as the per-port command buffer.
// Latency: 1 cycle from enqueue to head visible; head is a registered read.
// Backpressure: ready_o drops when all els_p entries are occupied.
module bp_mem_cmd_router_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_rd_ptr, r_wr_ptr;
    logic [cnt_w_lp-1:0] r_cnt;
    logic                w_enq, w_deq;

    assign ready_o = (r_cnt != cnt_w_lp'(els_p));
    assign v_o     = (r_cnt != '0);
    assign data_o  = r_mem[r_rd_ptr];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;

    function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Storage write; contents need no reset since occupancy gates the head
    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wr_ptr] <= data_i;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= bump(r_wr_ptr);
            if (w_deq) r_rd_ptr <= bump(r_rd_ptr);
            if (w_enq && !w_deq)      r_cnt <= r_cnt + cnt_w_lp'(1);
            else if (!w_enq && w_deq) r_cnt <= r_cnt - cnt_w_lp'(1);
        end
    end
endmodule

// Buffers UCE commands per port, round-robins them onto mem/io/clint, routes responses by lce_id.
// Latency: 1 cycle from command accept to downstream valid; responses pass through combinationally.
// Backpressure: per-port FIFO ready; a port blocked by its destination or credits never stalls others.
module bp_mem_cmd_router
    import bp_mem_pkg::*;
#(
    parameter bp_params_e bp_params_p       = e_bp_inv_cfg,
    parameter int         num_ports_p       = 2,
    parameter int         fifo_els_p        = 2,
    parameter int         max_outstanding_p = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  bp_cce_mem_msg_s [num_ports_p-1:0]   port_cmd_i,
    input  logic [num_ports_p-1:0]              port_cmd_v_i,
    output logic [num_ports_p-1:0]              port_cmd_ready_o,
    output bp_cce_mem_msg_s [num_ports_p-1:0]   port_resp_o,
    output logic [num_ports_p-1:0]              port_resp_v_o,
    input  logic [num_ports_p-1:0]              port_resp_yumi_i,
    output bp_cce_mem_msg_s                     mem_cmd_o,
    output logic                                mem_cmd_v_o,
    input  logic                                mem_cmd_ready_i,
    output bp_cce_mem_msg_s                     io_cmd_o,
    output logic                                io_cmd_v_o,
    input  logic                                io_cmd_ready_i,
    output bp_cce_mem_msg_s                     clint_cmd_o,
    output logic                                clint_cmd_v_o,
    input  logic                                clint_cmd_ready_i,
    input  bp_cce_mem_msg_s                     mem_resp_i,
    input  logic                                mem_resp_v_i,
    output logic                                mem_resp_yumi_o,
    input  bp_cce_mem_msg_s                     io_resp_i,
    input  logic                                io_resp_v_i,
    output logic                                io_resp_yumi_o,
    input  bp_cce_mem_msg_s                     clint_resp_i,
    input  logic                                clint_resp_v_i,
    output logic                                clint_resp_yumi_o,
    output logic [num_ports_p-1:0]              credits_full_o,
    output logic [num_ports_p-1:0]              credits_empty_o,
    output logic                                resp_err_o
);
    localparam logic [paddr_width_gp-1:0] dram_base_lp = dram_base(bp_params_p);
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
    localparam int rr_w_lp  = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;

    typedef enum logic [1:0] {e_dest_mem, e_dest_io, e_dest_clint} dest_e;

    function automatic dest_e decode(input logic [paddr_width_gp-1:0] addr);
        if ((addr < dram_base_lp) && (addr[23:20] == host_dev_gp))  return e_dest_io;
        if ((addr < dram_base_lp) && (addr[23:20] == clint_dev_gp)) return e_dest_clint;
        return e_dest_mem;
    endfunction

    bp_cce_mem_msg_s          w_head [num_ports_p];
    dest_e                    w_dest [num_ports_p];
    logic [num_ports_p-1:0]   w_head_v, w_fifo_ready, w_deq, w_elig, w_resp_fire;
    logic [rr_w_lp-1:0]       r_rr, w_gnt_idx, w_scan;
    logic                     w_gnt_v;
    dest_e                    w_gnt_dest;
    bp_cce_mem_msg_s          w_gnt_msg;
    bp_cce_mem_msg_s          w_src_msg [3];   // index order is priority: clint, io, mem
    logic [2:0]               w_src_v, w_src_yumi, w_src_bad;
    logic                     r_err;

    for (genvar i = 0; i < num_ports_p; i++) begin : g_port
        logic [cnt_w_lp-1:0] r_out;
        logic                w_dst_rdy;

        bp_mem_cmd_router_fifo #(
            .width_p ($bits(bp_cce_mem_msg_s)),
            .els_p   (fifo_els_p)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .data_i  (port_cmd_i[i]),
            .v_i     (port_cmd_v_i[i]),
            .ready_o (w_fifo_ready[i]),
            .data_o  (w_head[i]),
            .v_o     (w_head_v[i]),
            .yumi_i  (w_deq[i])
        );

        assign port_cmd_ready_o[i] = w_fifo_ready[i] & ~reset_i;
        assign w_dest[i]    = decode(w_head[i].addr);
        assign w_dst_rdy    = (w_dest[i] == e_dest_io)    ? io_cmd_ready_i :
                              (w_dest[i] == e_dest_clint) ? clint_cmd_ready_i : mem_cmd_ready_i;
        assign w_elig[i]    = ~reset_i & w_head_v[i] & w_dst_rdy
                            & (r_out < cnt_w_lp'(max_outstanding_p));
        assign w_deq[i]     = w_gnt_v & (w_gnt_idx == rr_w_lp'(i));
        assign w_resp_fire[i] = port_resp_v_o[i] & port_resp_yumi_i[i];

        assign credits_full_o[i]  = (r_out == cnt_w_lp'(max_outstanding_p));
        assign credits_empty_o[i] = reset_i | ((r_out == '0) & ~w_head_v[i]);

        // Count commands granted downstream that have not yet been answered
        always_ff @(posedge clk_i) begin
            if (reset_i)
                r_out <= '0;
            else if (w_deq[i] && !w_resp_fire[i] && (r_out != cnt_w_lp'(max_outstanding_p)))
                r_out <= r_out + cnt_w_lp'(1);
            else if (!w_deq[i] && w_resp_fire[i] && (r_out != '0))
                r_out <= r_out - cnt_w_lp'(1);
        end
    end

    // Round-robin pick: first eligible port at or after r_rr
    always_comb begin
        w_gnt_v   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int off = 0; off < num_ports_p; off++) begin
            w_scan = rr_w_lp'((int'(r_rr) + off) % num_ports_p);
            if (!w_gnt_v && w_elig[w_scan]) begin
                w_gnt_v   = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    assign w_gnt_dest = w_dest[w_gnt_idx];
    assign w_gnt_msg  = w_head[w_gnt_idx];

    assign mem_cmd_o     = w_gnt_msg;
    assign io_cmd_o      = w_gnt_msg;
    assign clint_cmd_o   = w_gnt_msg;
    assign mem_cmd_v_o   = w_gnt_v & (w_gnt_dest == e_dest_mem);
    assign io_cmd_v_o    = w_gnt_v & (w_gnt_dest == e_dest_io);
    assign clint_cmd_v_o = w_gnt_v & (w_gnt_dest == e_dest_clint);

    // Rotate priority past the port just served
    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_rr <= '0;
        else if (w_gnt_v)
            r_rr <= (w_gnt_idx == rr_w_lp'(num_ports_p - 1)) ? '0 : w_gnt_idx + rr_w_lp'(1);
    end

    assign w_src_msg[0] = clint_resp_i;
    assign w_src_msg[1] = io_resp_i;
    assign w_src_msg[2] = mem_resp_i;
    assign w_src_v      = {mem_resp_v_i, io_resp_v_i, clint_resp_v_i} & {3{~reset_i}};

    // Steer each response to its port; bad lce_ids are swallowed and flagged
    always_comb begin
        port_resp_v_o = '0;
        port_resp_o   = '0;
        w_src_yumi    = '0;
        w_src_bad     = '0;
        for (int s = 0; s < 3; s++) begin
            if (w_src_v[s] && (int'(w_src_msg[s].lce_id) >= num_ports_p)) begin
                w_src_bad[s]  = 1'b1;
                w_src_yumi[s] = 1'b1;
            end
        end
        for (int p = 0; p < num_ports_p; p++) begin
            for (int s = 0; s < 3; s++) begin
                if (!port_resp_v_o[p] && w_src_v[s] && (int'(w_src_msg[s].lce_id) == p)) begin
                    port_resp_v_o[p] = 1'b1;
                    port_resp_o[p]   = w_src_msg[s];
                    w_src_yumi[s]    = port_resp_yumi_i[p];
                end
            end
        end
    end

    assign clint_resp_yumi_o = w_src_yumi[0];
    assign io_resp_yumi_o    = w_src_yumi[1];
    assign mem_resp_yumi_o   = w_src_yumi[2];

    // Sticky misroute flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (reset_i)         r_err <= 1'b0;
        else if (|w_src_bad) r_err <= 1'b1;
    end

    assign resp_err_o = r_err;
endmodule

// File: tb/tb_bp_mem_cmd_router.sv
// Self-checking bench for bp_mem_cmd_router (4 ports): vector table, directed sequences, random vs model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 2 units later.
// Backpressure: readies and yumis are driven explicitly per scenario.
module tb_bp_mem_cmd_router;
    import bp_mem_pkg::*;

    localparam int NP = 4;
    localparam int FE = 2;
    localparam int MO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    bp_cce_mem_msg_s [NP-1:0] port_cmd, port_resp;
    logic [NP-1:0] port_cmd_v, port_cmd_ready, port_resp_v, port_resp_yumi, cfull, cempty;
    bp_cce_mem_msg_s mem_cmd, io_cmd, clint_cmd, mem_resp, io_resp, clint_resp;
    logic mem_cmd_v, io_cmd_v, clint_cmd_v, mem_rdy, io_rdy, clint_rdy;
    logic mem_resp_v, io_resp_v, clint_resp_v, mem_yumi, io_yumi, clint_yumi, rerr;
    logic [2:0] v3, syumi;
    assign v3    = {clint_cmd_v, io_cmd_v, mem_cmd_v};
    assign syumi = {mem_yumi, io_yumi, clint_yumi};

    bp_mem_cmd_router #(.bp_params_p(e_bp_inv_cfg), .num_ports_p(NP), .fifo_els_p(FE),
                        .max_outstanding_p(MO)) dut (
        .clk_i(clk), .reset_i(reset),
        .port_cmd_i(port_cmd), .port_cmd_v_i(port_cmd_v), .port_cmd_ready_o(port_cmd_ready),
        .port_resp_o(port_resp), .port_resp_v_o(port_resp_v), .port_resp_yumi_i(port_resp_yumi),
        .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_rdy),
        .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_ready_i(io_rdy),
        .clint_cmd_o(clint_cmd), .clint_cmd_v_o(clint_cmd_v), .clint_cmd_ready_i(clint_rdy),
        .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_yumi),
        .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_yumi_o(io_yumi),
        .clint_resp_i(clint_resp), .clint_resp_v_i(clint_resp_v), .clint_resp_yumi_o(clint_yumi),
        .credits_full_o(cfull), .credits_empty_o(cempty), .resp_err_o(rerr)
    );

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct { logic [39:0] addr; int dest; } dvec_t;   // dest: 0 mem, 1 io, 2 clint
    dvec_t dv [8];
    logic [39:0] raddr [6];

    bp_cce_mem_msg_s mq [NP][$];
    int mout [NP];
    int mrr;
    bit merr;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bp_cce_mem_msg_s mk(input int lce, input logic [39:0] addr, input logic [63:0] data);
        bp_cce_mem_msg_s m;
        m = '0;
        m.msg_type = 4'h3;
        m.lce_id = 4'(lce);
        m.addr = addr;
        m.data = data;
        return m;
    endfunction

    function automatic int mdest(input logic [39:0] a);
        if (a < 40'h00_8000_0000) begin
            if (a[23:20] == 4'd1) return 1;
            if (a[23:20] == 4'd2) return 2;
        end
        return 0;
    endfunction

    function automatic bp_cce_mem_msg_s chan(input int d);
        if (d == 1) return io_cmd;
        if (d == 2) return clint_cmd;
        return mem_cmd;
    endfunction

    function automatic logic dest_rdy(input int d);
        if (d == 1) return io_rdy;
        if (d == 2) return clint_rdy;
        return mem_rdy;
    endfunction

    task automatic idle();
        port_cmd = '0; port_cmd_v = '0; port_resp_yumi = '0;
        mem_rdy = 1'b1; io_rdy = 1'b1; clint_rdy = 1'b1;
        mem_resp = '0; io_resp = '0; clint_resp = '0;
        mem_resp_v = 1'b0; io_resp_v = 1'b0; clint_resp_v = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_random(input int ncyc);
        bp_cce_mem_msg_s smsg [3];
        logic [2:0] sv, exp_sy;
        logic [NP-1:0] exp_prv, exp_rdy, exp_full, exp_empty;
        bp_cce_mem_msg_s exp_presp [NP];
        int g, d, k;
        bit newerr;
        do_reset();
        for (int p = 0; p < NP; p++) begin mq[p].delete(); mout[p] = 0; end
        mrr = 0; merr = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            for (int p = 0; p < NP; p++) begin
                port_cmd[p] = mk(p, raddr[$urandom_range(0, 5)], {$urandom, $urandom});
                port_cmd_v[p] = ($urandom_range(0, 1) == 1);
            end
            mem_rdy = ($urandom_range(0, 3) != 0);
            io_rdy = ($urandom_range(0, 3) != 0);
            clint_rdy = ($urandom_range(0, 3) != 0);
            clint_resp = mk(($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, NP-1), 40'h0, {$urandom, $urandom});
            io_resp = mk(($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, NP-1), 40'h0, {$urandom, $urandom});
            mem_resp = mk(($urandom_range(0, 15) == 0) ? 5 : $urandom_range(0, NP-1), 40'h0, {$urandom, $urandom});
            clint_resp_v = ($urandom_range(0, 1) == 1);
            io_resp_v = ($urandom_range(0, 1) == 1);
            mem_resp_v = ($urandom_range(0, 1) == 1);
            port_resp_yumi = NP'($urandom);
            #2;
            // command side expectations
            g = -1;
            for (int off = 0; off < NP; off++) begin
                k = (mrr + off) % NP;
                if (g < 0 && mq[k].size() > 0 && dest_rdy(mdest(mq[k][0].addr)) && mout[k] < MO) g = k;
            end
            for (int p = 0; p < NP; p++) begin
                exp_rdy[p] = (mq[p].size() < FE);
                exp_full[p] = (mout[p] == MO);
                exp_empty[p] = (mout[p] == 0) && (mq[p].size() == 0);
            end
            check("rnd_ready", 128'(port_cmd_ready), 128'(exp_rdy));
            check("rnd_full", 128'(cfull), 128'(exp_full));
            check("rnd_empty", 128'(cempty), 128'(exp_empty));
            d = (g >= 0) ? mdest(mq[g][0].addr) : 0;
            check("rnd_cmd_v", 128'(v3), (g >= 0) ? 128'(1 << d) : 128'(0));
            if (g >= 0) check("rnd_cmd_dat", 128'(chan(d)), 128'(mq[g][0]));
            // response side expectations
            smsg[0] = clint_resp; smsg[1] = io_resp; smsg[2] = mem_resp;
            sv = {mem_resp_v, io_resp_v, clint_resp_v};
            exp_prv = '0; exp_sy = '0; newerr = 1'b0;
            for (int p = 0; p < NP; p++) exp_presp[p] = '0;
            for (int s = 0; s < 3; s++)
                if (sv[s] && int'(smsg[s].lce_id) >= NP) begin exp_sy[s] = 1'b1; newerr = 1'b1; end
            for (int p = 0; p < NP; p++) begin
                k = -1;
                if (sv[0] && int'(smsg[0].lce_id) == p) k = 0;
                else if (sv[1] && int'(smsg[1].lce_id) == p) k = 1;
                else if (sv[2] && int'(smsg[2].lce_id) == p) k = 2;
                if (k >= 0) begin
                    exp_prv[p] = 1'b1;
                    exp_presp[p] = smsg[k];
                    exp_sy[k] = port_resp_yumi[p];
                end
            end
            check("rnd_resp_v", 128'(port_resp_v), 128'(exp_prv));
            check("rnd_src_yumi", 128'(syumi), 128'(exp_sy));
            for (int p = 0; p < NP; p++)
                if (exp_prv[p]) check("rnd_resp_dat", 128'(port_resp[p]), 128'(exp_presp[p]));
            check("rnd_err", 128'(rerr), 128'(merr));
            // advance the model to the next cycle
            if (g >= 0) void'(mq[g].pop_front());
            for (int p = 0; p < NP; p++) begin
                if (port_cmd_v[p] && exp_rdy[p]) mq[p].push_back(port_cmd[p]);
                if ((p == g) && !(exp_prv[p] && port_resp_yumi[p])) mout[p]++;
                else if ((p != g) && exp_prv[p] && port_resp_yumi[p] && mout[p] > 0) mout[p]--;
            end
            if (g >= 0) mrr = (g + 1) % NP;
            merr = merr | newerr;
            tick();
        end
        idle();
    endtask

    initial begin
        int sent, grants;
        logic anyv;

        dv[0] = '{40'h00_8000_1000, 0};
        dv[1] = '{40'h00_0020_0000, 2};
        dv[2] = '{40'h00_0010_0000, 1};
        dv[3] = '{40'h00_0030_0000, 0};
        dv[4] = '{40'h00_7FF0_0000, 0};
        dv[5] = '{40'h00_7F1F_FFFF, 1};
        dv[6] = '{40'h00_8010_0000, 0};
        dv[7] = '{40'h00_8020_0000, 0};
        raddr[0] = 40'h00_8000_1000; raddr[1] = 40'h00_0010_0040; raddr[2] = 40'h00_0020_0080;
        raddr[3] = 40'h00_0030_0000; raddr[4] = 40'h00_7F1F_FFF0; raddr[5] = 40'h00_8010_0000;

        // reset state, with traffic offered while reset is high
        reset = 1'b1;
        idle();
        port_cmd_v = '1;
        mem_resp = mk(0, 40'h0, 64'h11); mem_resp_v = 1'b1; port_resp_yumi = '1;
        tick();
        #2;
        check("rst_ready", 128'(port_cmd_ready), 128'(0));
        check("rst_cmd_v", 128'(v3), 128'(0));
        check("rst_resp_v", 128'(port_resp_v), 128'(0));
        check("rst_yumi", 128'(syumi), 128'(0));
        check("rst_empty", 128'(cempty), 128'(4'hF));
        check("rst_err", 128'(rerr), 128'(0));
        idle();
        reset = 1'b0;
        tick();
        #2;
        check("post_rst_ready", 128'(port_cmd_ready), 128'(4'hF));
        check("post_rst_empty", 128'(cempty), 128'(4'hF));

        // address decode table, one command on port 0 each
        for (int i = 0; i < 8; i++) begin
            do_reset();
            port_cmd[0] = mk(0, dv[i].addr, 64'hD0 + 64'(i));
            port_cmd_v[0] = 1'b1;
            #2;
            check("dec_same_cycle", 128'(v3), 128'(0));
            tick();
            port_cmd_v[0] = 1'b0;
            #2;
            check("dec_v", 128'(v3), 128'(1 << dv[i].dest));
            check("dec_dat", 128'(chan(dv[i].dest)), 128'(mk(0, dv[i].addr, 64'hD0 + 64'(i))));
        end

        // single mem command and its response
        do_reset();
        port_cmd[0] = mk(0, 40'h00_8000_1000, 64'hCAFE);
        port_cmd_v[0] = 1'b1;
        tick();
        port_cmd_v[0] = 1'b0;
        #2;
        check("single_v", 128'(mem_cmd_v), 128'(1));
        check("single_dat", 128'(mem_cmd), 128'(mk(0, 40'h00_8000_1000, 64'hCAFE)));
        tick();
        #2;
        check("single_idle", 128'(v3), 128'(0));
        check("single_out1", 128'(cempty[0]), 128'(0));
        mem_resp = mk(0, 40'h0, 64'hBEEF); mem_resp_v = 1'b1; port_resp_yumi[0] = 1'b1;
        #2;
        check("single_resp_v", 128'(port_resp_v), 128'(1));
        check("single_resp_dat", 128'(port_resp[0]), 128'(mk(0, 40'h0, 64'hBEEF)));
        check("single_yumi", 128'(mem_yumi), 128'(1));
        tick();
        idle();
        #2;
        check("single_out0", 128'(cempty[0]), 128'(1));

        // round robin over four continuously valid ports
        do_reset();
        for (int p = 0; p < NP; p++) port_cmd[p] = mk(p, 40'h00_8000_0000 + 40'(p * 64), 64'(p));
        port_cmd_v = '1;
        for (int n = 0; n < 6; n++) begin
            tick();
            #2;
            check("rr_v", 128'(mem_cmd_v), 128'(1));
            check("rr_port", 128'(mem_cmd.lce_id), 128'(n % 4));
        end
        idle();

        // destination not ready must not block another port
        do_reset();
        mem_rdy = 1'b0;
        port_cmd[0] = mk(0, 40'h00_8000_4000, 64'hA0);
        port_cmd[1] = mk(1, 40'h00_0010_0000, 64'hB1);
        port_cmd_v = 4'b0011;
        tick();
        port_cmd_v = '0;
        #2;
        check("hol_v", 128'(v3), 128'(3'b010));
        check("hol_dat", 128'(io_cmd), 128'(mk(1, 40'h00_0010_0000, 64'hB1)));
        tick();
        #2;
        check("hol_wait", 128'(v3), 128'(0));
        mem_rdy = 1'b1;
        #2;
        check("hol_release", 128'(v3), 128'(3'b001));
        check("hol_rel_dat", 128'(mem_cmd), 128'(mk(0, 40'h00_8000_4000, 64'hA0)));

        // credit limit on port 0
        do_reset();
        sent = 0; grants = 0;
        for (int c = 0; c < 20; c++) begin
            port_cmd[0] = mk(0, 40'h00_8000_2000, 64'(sent));
            port_cmd_v[0] = (sent < 6);
            #2;
            if (mem_cmd_v) grants++;
            if (port_cmd_v[0] && port_cmd_ready[0]) sent++;
            tick();
        end
        port_cmd_v = '0;
        #2;
        check("cred_grants", 128'(grants), 128'(MO));
        check("cred_full", 128'(cfull[0]), 128'(1));
        check("cred_fifo_full", 128'(port_cmd_ready[0]), 128'(0));
        check("cred_stall", 128'(mem_cmd_v), 128'(0));
        mem_resp = mk(0, 40'h0, 64'h1); mem_resp_v = 1'b1; port_resp_yumi[0] = 1'b1;
        tick();
        mem_resp_v = 1'b0; port_resp_yumi = '0;
        #2;
        check("cred_resume_v", 128'(mem_cmd_v), 128'(1));
        check("cred_resume_dat", 128'(mem_cmd.data), 128'(4));
        check("cred_not_full", 128'(cfull[0]), 128'(0));

        // response priority, parallel delivery and misroute
        do_reset();
        clint_resp = mk(1, 40'h0, 64'hC1); mem_resp = mk(1, 40'h0, 64'hA1); io_resp = mk(2, 40'h0, 64'hB2);
        clint_resp_v = 1'b1; mem_resp_v = 1'b1; io_resp_v = 1'b1;
        port_resp_yumi = 4'b0110;
        #2;
        check("resp_v", 128'(port_resp_v), 128'(4'b0110));
        check("resp_p1_clint", 128'(port_resp[1]), 128'(mk(1, 40'h0, 64'hC1)));
        check("resp_p2_io", 128'(port_resp[2]), 128'(mk(2, 40'h0, 64'hB2)));
        check("resp_yumis", 128'(syumi), 128'(3'b011));
        port_resp_yumi = 4'b0000;
        #2;
        check("resp_no_yumi", 128'(syumi), 128'(0));
        port_resp_yumi = 4'b0110;
        tick();
        clint_resp_v = 1'b0; io_resp_v = 1'b0;
        #2;
        check("resp_p1_mem", 128'(port_resp[1]), 128'(mk(1, 40'h0, 64'hA1)));
        check("resp_mem_yumi", 128'(syumi), 128'(3'b100));
        tick();
        idle();
        io_resp = mk(5, 40'h0, 64'hE5); io_resp_v = 1'b1;
        #2;
        check("err_consume", 128'(io_yumi), 128'(1));
        check("err_no_port", 128'(port_resp_v), 128'(0));
        tick();
        io_resp_v = 1'b0;
        #2;
        check("err_set", 128'(rerr), 128'(1));
        tick(); tick(); tick();
        #2;
        check("err_sticky", 128'(rerr), 128'(1));
        do_reset();
        #2;
        check("err_cleared", 128'(rerr), 128'(0));

        // reset with two commands buffered
        do_reset();
        mem_rdy = 1'b0;
        port_cmd[0] = mk(0, 40'h00_8000_3000, 64'h77);
        port_cmd_v[0] = 1'b1;
        tick(); tick();
        port_cmd_v = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        mem_rdy = 1'b1;
        anyv = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            anyv = anyv | (|v3);
            tick();
        end
        check("rstmid_no_cmd", 128'(anyv), 128'(0));
        check("rstmid_empty", 128'(cempty), 128'(4'hF));
        check("rstmid_full", 128'(cfull), 128'(0));

        // randomized traffic against the reference model
        run_random(600);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
